axis_pool_window_reorder: RTL and testbench
===========================================

AXIS_POOL_WINDOW_REORDER -- requirements
Module: axis_pool_window_reorder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: pixel width in bits.
REQ-002 SHALL have parameter Win, default 28: input map width in pixels; even, >= 2.
REQ-003 SHALL have parameter Hin, default 28: input map height in pixels; even, >= 2.
REQ-004 SHALL have parameter N, default 6: channel maps per frame, >= 1.
REQ-005 SHALL have port aclk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port areset, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port s_axis_tdata, input, WIDTH: raster-order pixel in.
REQ-008 SHALL have port s_axis_tvalid, input, 1: input beat valid.
REQ-009 SHALL have port s_axis_tready, output, 1: block accepts input beat.
REQ-010 SHALL have port m_axis_tdata, output, WIDTH: window-ordered pixel out, to 2x2/stride-2 maxpool stage.
REQ-011 SHALL have port m_axis_tvalid, output, 1: output beat valid.
REQ-012 SHALL have port m_axis_tready, input, 1: downstream accepts beat.
REQ-013 SHALL have port m_axis_tlast, output, 1: final beat of a channel map.

Function
REQ-014 SHALL accept input in raster order: column fastest, then row, then channel; a beat transfers when s_axis_tvalid && s_axis_tready.
REQ-015 SHALL emit, per 2x2 window (row pair r,r+1; column pair c,c+1; r,c even), exactly 4 beats in order p(r,c), p(r,c+1), p(r+1,c), p(r+1,c+1).
REQ-016 SHALL emit windows left-to-right within a row pair, row pairs top-to-bottom, channels 0..N-1; (Win/2)*(Hin/2)*4 beats per channel.
REQ-017 SHALL keep pixel-column, row and channel counters; column wraps at Win-1 advancing row; row wraps at Hin-1 advancing channel; channel wraps at N-1 to 0 with no idle gap (continuous frames).
REQ-018 SHALL store even (top) rows in a line buffer of Win/2 entries, each 2*WIDTH bits (pixel pair), written when the odd-column pixel of the pair is accepted.
REQ-019 SHALL implement states TOP, BOT_A, BOT_B, EMIT.
REQ-020 TOP: s_axis_tready=1; accepted beats fill line buffer; after column Win-1 of an even row -> BOT_A.
REQ-021 BOT_A: s_axis_tready=1; accepted even-column pixel latched in hold register -> BOT_B.
REQ-022 BOT_B: s_axis_tready=1; on accepted odd-column pixel, load all 4 window pixels into the output registers -> EMIT with beat index 0.
REQ-023 EMIT: s_axis_tready=0, m_axis_tvalid=1; beat index advances only when m_axis_tready=1; after beat 3 accepted -> BOT_A if more columns remain in the row pair, else TOP.
REQ-024 SHALL present the first beat of a window on the cycle after the completing bottom pixel is accepted (1-cycle latency).
REQ-025 SHALL hold m_axis_tdata and m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-026 SHALL assert m_axis_tlast only on beat 3 of the last window (bottom-right) of each channel map.
REQ-027 SHALL tolerate s_axis_tvalid gaps in any input state without data loss or reordering.
REQ-028 SHALL output m_axis_tvalid=0 in TOP, BOT_A, BOT_B; no combinational path from s_axis_tvalid to m_axis_tvalid.
REQ-029 SHALL make s_axis_tready a function of state only, not of m_axis_tready.
REQ-030 SHALL produce an elaboration-time error if Win or Hin is odd.

Reset
REQ-031 On areset=1 at a rising edge: state=TOP, all counters=0, beat index=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0 during reset cycle then 1 in TOP.
REQ-032 Reset asserted mid-frame (any state, including EMIT with beat pending) SHALL discard partial windows; the next accepted pixel is treated as p(0,0) of channel 0.
REQ-033 Line buffer contents need not be cleared by reset.

Verification
REQ-034 Win=Hin=4, N=1, ramp 0..15, m_axis_tready=1 -> output 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15; tlast only on 15.
REQ-035 Same stimulus, m_axis_tready toggling 1/0 each cycle -> identical sequence; tdata held during stalls; s_axis_tready=0 throughout each EMIT.
REQ-036 Default params, N=6, random pixels with random s_axis_tvalid gaps -> 4704 beats matching software 2x2 window order; tlast count 6, every 784th beat.
REQ-037 Win=Hin=4, N=2, ramp 0..31 continuous -> channel 1 output begins 16,17,20,21 immediately after channel 0 tlast; then second frame restarts at channel 0.
REQ-038 Win=Hin=4, assert areset during EMIT of second window, then ramp 100..115 -> m_axis_tvalid=0 the cycle after reset; output 100,101,104,105,... with no stale beats.

Source files
------------

// File: rtl/axis_pool_window_reorder.sv
// axis_pool_window_reorder
// Reorders a raster-order pixel stream into 2x2 window order for a
// stride-2 max-pool stage. Top rows are kept in a line buffer of pixel pairs.
// Each completed window is emitted as four beats.
//
// state | meaning
// ------+--------------------------------------------------------------
// TOP   | accepting an even (top) row into the line buffer
// BOT_A | waiting for the even-column pixel of a bottom row
// BOT_B | waiting for the odd-column pixel that completes a window
// EMIT  | presenting the four window beats downstream, input stalled
module axis_pool_window_reorder #(
    parameter int WIDTH = 8,
    parameter int Win   = 28,
    parameter int Hin   = 28,
    parameter int N     = 6
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
);

    localparam int CW = ($clog2(Win) < 2) ? 2 : $clog2(Win);
    localparam int RW = ($clog2(Hin) < 1) ? 1 : $clog2(Hin);
    localparam int NW = (N < 2) ? 1 : $clog2(N);
    localparam logic [CW-1:0] COL_LAST = CW'(Win - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(Hin - 1);
    localparam logic [NW-1:0] CH_LAST  = NW'(N - 1);

    generate
        if ((Win % 2) != 0 || (Hin % 2) != 0 || Win < 2 || Hin < 2) begin : g_bad_dims
            $error("axis_pool_window_reorder: Win and Hin must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {TOP, BOT_A, BOT_B, EMIT} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [NW-1:0]     ch;
    logic [1:0]        beat;
    logic [WIDTH-1:0]  hold;
    logic [WIDTH-1:0]  data_r, w1, w2, w3;
    logic              last_win, last_r;
    logic [CW-2:0]     pidx;
    logic              accept, fire;
    logic [2*WIDTH-1:0] lbuf [Win/2];

    assign pidx          = col[CW-1:1];
    assign s_axis_tready = !areset && (state != EMIT);
    assign m_axis_tvalid = (state == EMIT);
    assign m_axis_tdata  = data_r;
    assign m_axis_tlast  = last_r;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign fire          = m_axis_tvalid && m_axis_tready;

    // Next-state decode; column counter has already advanced when EMIT ends,
    // so col == 0 there means the row pair is finished.
    always_comb begin
        state_nxt = state;
        case (state)
            TOP:     if (accept && col == COL_LAST) state_nxt = BOT_A;
            BOT_A:   if (accept) state_nxt = BOT_B;
            BOT_B:   if (accept) state_nxt = EMIT;
            EMIT:    if (fire && beat == 2'd3) state_nxt = (col == '0) ? TOP : BOT_A;
            default: state_nxt = TOP;
        endcase
    end

    // State, position counters, window shift register and tlast.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= TOP;
            col      <= '0;
            row      <= '0;
            ch       <= '0;
            beat     <= '0;
            hold     <= '0;
            data_r   <= '0;
            w1       <= '0;
            w2       <= '0;
            w3       <= '0;
            last_win <= 1'b0;
            last_r   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    if (row == ROW_LAST) begin
                        row <= '0;
                        ch  <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
                if (!col[0]) hold <= s_axis_tdata;
            end
            if (state == BOT_B && accept) begin
                data_r   <= lbuf[pidx][WIDTH-1:0];
                w1       <= lbuf[pidx][2*WIDTH-1:WIDTH];
                w2       <= hold;
                w3       <= s_axis_tdata;
                last_win <= (col == COL_LAST) && (row == ROW_LAST);
                beat     <= '0;
                last_r   <= 1'b0;
            end else if (fire) begin
                data_r <= w1;
                w1     <= w2;
                w2     <= w3;
                beat   <= beat + 2'd1;
                last_r <= (beat == 2'd2) && last_win;
            end
        end
    end

    // Line buffer write: the pair is stored once its odd-column pixel arrives.
    always_ff @(posedge aclk) begin
        if (state == TOP && accept && col[0]) lbuf[pidx] <= {s_axis_tdata, hold};
    end

endmodule

// File: tb/tb_axis_pool_window_reorder.sv
// Testbench for axis_pool_window_reorder: random and ramp stimulus against a
// window-order reference model, including stalls, gaps and mid-frame reset.
module tb_axis_pool_window_reorder;

    localparam int W  = 8;
    localparam int WI = 4;
    localparam int HI = 4;
    localparam int NC = 2;
    localparam int PIX = WI * HI;

    logic         aclk = 1'b0;
    logic         areset;
    logic [W-1:0] s_d;
    logic         s_v, s_r;
    logic [W-1:0] m_d;
    logic         m_v, m_r, m_l;

    always #5 aclk = ~aclk;

    axis_pool_window_reorder #(.WIDTH(W), .Win(WI), .Hin(HI), .N(NC)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_d),
        .s_axis_tvalid (s_v),
        .s_axis_tready (s_r),
        .m_axis_tdata  (m_d),
        .m_axis_tvalid (m_v),
        .m_axis_tready (m_r),
        .m_axis_tlast  (m_l)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    logic [W-1:0] img [HI][WI];
    int           pos = 0;
    logic [W-1:0] exp_d[$];
    bit           exp_l[$];
    logic [W-1:0] out_log[$];
    logic [W-1:0] src[$];
    int           last_cnt = 0;
    bit           tog = 1'b1;

    // One clock: drive at negedge, check and observe 1 time unit later.
    task automatic cycle(input bit rst, input bit sv, input logic [W-1:0] sd,
                         input bit mr, output bit acc);
        int r, c;
        @(negedge aclk);
        areset = rst;
        s_v    = sv;
        s_d    = sd;
        m_r    = mr;
        #1;
        acc = 1'b0;
        if (rst) begin
            check("s_ready_in_reset", 32'(s_r), 32'd0);
            pos = 0;
            exp_d.delete();
            exp_l.delete();
            return;
        end
        check("m_valid", 32'(m_v), 32'(exp_d.size() > 0));
        check("s_ready", 32'(s_r), 32'(exp_d.size() == 0));
        if (exp_d.size() > 0) begin
            check("m_data", 32'(m_d), 32'(exp_d[0]));
            check("m_last", 32'(m_l), 32'(exp_l[0]));
            if (mr) begin
                out_log.push_back(m_d);
                if (m_l) last_cnt++;
                void'(exp_d.pop_front());
                void'(exp_l.pop_front());
            end
        end
        if (sv && s_r) begin
            acc = 1'b1;
            r = pos / WI;
            c = pos % WI;
            img[r][c] = sd;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                exp_d.push_back(img[r-1][c-1]); exp_l.push_back(1'b0);
                exp_d.push_back(img[r-1][c]);   exp_l.push_back(1'b0);
                exp_d.push_back(img[r][c-1]);   exp_l.push_back(1'b0);
                exp_d.push_back(sd);            exp_l.push_back((r == HI-1) && (c == WI-1));
            end
            pos = (pos + 1) % PIX;
        end
    endtask

    // Stream src through the DUT until both input and expected output drain.
    // mode: 0 always ready, 1 ready toggles each cycle, 2 random ready.
    task automatic run(input int gap_pct, input int mode, input int max_cycles);
        bit acc, v, mr;
        logic [W-1:0] d;
        int n = 0;
        while ((src.size() > 0 || exp_d.size() > 0) && n < max_cycles) begin
            v = (src.size() > 0) && ($urandom_range(99) >= gap_pct);
            d = v ? src[0] : W'($urandom);
            case (mode)
                0:       mr = 1'b1;
                1:       begin mr = tog; tog = !tog; end
                default: mr = 1'($urandom_range(1));
            endcase
            cycle(1'b0, v, d, mr, acc);
            if (acc) void'(src.pop_front());
            n++;
        end
        check("run_timeout", 32'(n < max_cycles), 32'd1);
    endtask

    logic [W-1:0] ref_ramp [16];
    logic [W-1:0] tmp;
    bit           acc;
    int           n;

    initial begin
        ref_ramp = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        areset = 1'b1; s_v = 1'b0; s_d = '0; m_r = 1'b0;

        // reset behaviour
        cycle(1'b1, 1'b0, '0, 1'b0, acc);
        cycle(1'b1, 1'b0, '0, 1'b0, acc);
        cycle(1'b0, 1'b0, '0, 1'b1, acc);
        check("rst_tdata", 32'(m_d), 32'd0);
        check("rst_tlast", 32'(m_l), 32'd0);

        // ramp 0..63: two full frames of two channels, always ready
        out_log.delete(); last_cnt = 0;
        for (int i = 0; i < 2 * NC * PIX; i++) begin tmp = W'(i); src.push_back(tmp); end
        run(0, 0, 500);
        check("ramp_beats", 32'(out_log.size()), 32'(2 * NC * PIX));
        for (int i = 0; i < 16; i++) check("ramp_ch0_order", 32'(out_log[i]), 32'(ref_ramp[i]));
        check("ch1_b0", 32'(out_log[16]), 32'd16);
        check("ch1_b1", 32'(out_log[17]), 32'd17);
        check("ch1_b2", 32'(out_log[18]), 32'd20);
        check("ch1_b3", 32'(out_log[19]), 32'd21);
        check("frame2_b0", 32'(out_log[32]), 32'd32);
        check("ramp_tlast_cnt", 32'(last_cnt), 32'(2 * NC));

        // same ramp with downstream ready toggling each cycle
        out_log.delete(); last_cnt = 0; tog = 1'b1;
        for (int i = 0; i < NC * PIX; i++) begin tmp = W'(i); src.push_back(tmp); end
        run(0, 1, 1000);
        for (int i = 0; i < 16; i++) check("toggle_order", 32'(out_log[i]), 32'(ref_ramp[i]));
        check("toggle_tlast_cnt", 32'(last_cnt), 32'(NC));

        // random pixels, input gaps and random backpressure over several frames
        out_log.delete(); last_cnt = 0;
        for (int i = 0; i < 3 * NC * PIX; i++) begin tmp = W'($urandom); src.push_back(tmp); end
        run(35, 2, 5000);
        check("rand_beats", 32'(out_log.size()), 32'(3 * NC * PIX));
        check("rand_tlast_cnt", 32'(last_cnt), 32'(3 * NC));

        // reset during EMIT of the second window with a beat pending
        out_log.delete();
        for (int i = 0; i < PIX; i++) begin tmp = W'(200 + i); src.push_back(tmp); end
        n = 0;
        while (out_log.size() < 5 && n < 200) begin
            cycle(1'b0, src.size() > 0, (src.size() > 0) ? src[0] : '0, 1'b1, acc);
            if (acc) void'(src.pop_front());
            n++;
        end
        check("pre_reset_timeout", 32'(n < 200), 32'd1);
        cycle(1'b0, 1'b0, '0, 1'b0, acc);
        check("emit_before_reset", 32'(m_v), 32'd1);
        src.delete();
        cycle(1'b1, 1'b0, '0, 1'b0, acc);
        cycle(1'b0, 1'b0, '0, 1'b1, acc);
        check("valid_after_reset", 32'(m_v), 32'd0);
        out_log.delete();
        for (int i = 0; i < PIX; i++) begin tmp = W'(100 + i); src.push_back(tmp); end
        run(0, 0, 200);
        check("post_reset_beats", 32'(out_log.size()), 32'(PIX));
        check("post_reset_b0", 32'(out_log[0]), 32'd100);
        check("post_reset_b1", 32'(out_log[1]), 32'd101);
        check("post_reset_b2", 32'(out_log[2]), 32'd104);
        check("post_reset_b3", 32'(out_log[3]), 32'd105);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
